// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI transfer sequencer.
// Optional CS guard phases are selected by the SPI_CS_GUARD_EN macro in spi_xfer_seq.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_TRAIL   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_CPOL      = 0;
  localparam int DEF_CPHA      = 0;
  localparam int DEF_GUARD_CYC = 2;

  // Pulse-generator enable window: a late final read must still be accepted.
  function automatic logic work_window(input state_t s);
    return (s == ST_LEAD) || (s == ST_SHIFT) || (s == ST_WAIT_RD);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider for the SPI sequencer: emits 2*DATA_W toggles while en is high,
// with one-cycle edge pulses aligned to the cycle in which sclk changes level.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CPOL    = DEF_CPOL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic up_edge,
  output logic down_edge,
  output logic last_toggle
);

  localparam int   DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   TOG_W     = $clog2(2 * DATA_W + 1);
  localparam logic SCLK_IDLE = (CPOL != 0);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [TOG_W-1:0] tog_cnt_reg;
  logic             sclk_reg;
  logic             up_edge_reg;
  logic             down_edge_reg;
  logic             tog_full;
  logic             tick;

  assign tog_full = (tog_cnt_reg == TOG_W'(2 * DATA_W));
  assign tick     = en && !tog_full && (div_cnt_reg == DIV_W'(CLK_DIV - 1));

  // Dropping en restarts the divider so the next SHIFT entry starts a fresh half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg   <= '0;
      tog_cnt_reg   <= '0;
      sclk_reg      <= SCLK_IDLE;
      up_edge_reg   <= 1'b0;
      down_edge_reg <= 1'b0;
    end else if (!en) begin
      div_cnt_reg   <= '0;
      tog_cnt_reg   <= '0;
      sclk_reg      <= SCLK_IDLE;
      up_edge_reg   <= 1'b0;
      down_edge_reg <= 1'b0;
    end else begin
      up_edge_reg   <= tick && !sclk_reg;
      down_edge_reg <= tick && sclk_reg;
      if (tick) begin
        div_cnt_reg <= '0;
        sclk_reg    <= ~sclk_reg;
        tog_cnt_reg <= tog_cnt_reg + 1'b1;
      end else if (!tog_full) begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end

  assign sclk        = sclk_reg;
  assign up_edge     = up_edge_reg;
  assign down_edge   = down_edge_reg;
  assign last_toggle = tog_full;

endmodule

// File: rtl/spi_xfer_seq.sv
// SPI master frame sequencer driven by an external write/read pulse generator.
// Define SPI_CS_GUARD_EN to insert GUARD_CYC-cycle LEAD/TRAIL phases around SHIFT.
module spi_xfer_seq
  import spi_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int CPOL      = DEF_CPOL,
  parameter int CPHA      = DEF_CPHA,
  parameter int GUARD_CYC = DEF_GUARD_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_cs_n,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_work_en,
  output logic              o_up_edge,
  output logic              o_down_edge,
  input  logic              i_write_pulse,
  input  logic              i_read_pulse
);

  localparam int   RD_W      = $clog2(DATA_W + 1);
  localparam int   GRD_W     = $clog2(GUARD_CYC + 1);
  localparam logic SKIP_FIRST_WR = (CPHA != 0);

`ifdef SPI_CS_GUARD_EN
  localparam state_t AFTER_IDLE = ST_LEAD;
  localparam state_t AFTER_WAIT = ST_TRAIL;
`else
  localparam state_t AFTER_IDLE = ST_SHIFT;
  localparam state_t AFTER_WAIT = ST_DONE;
`endif

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic [RD_W-1:0]   rd_cnt_reg;
  logic [GRD_W-1:0]  guard_cnt_reg;
  logic              wr_seen_reg;
  logic              shift_en;
  logic              last_toggle;
  logic              guard_done;
  logic              rd_full;
  logic              in_frame;

  assign shift_en   = (state_reg == ST_SHIFT);
  assign in_frame   = (state_reg != ST_IDLE);
  assign guard_done = (guard_cnt_reg == GRD_W'(GUARD_CYC - 1));
  assign rd_full    = (rd_cnt_reg == RD_W'(DATA_W));

  spi_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (shift_en),
    .sclk        (o_sclk),
    .up_edge     (o_up_edge),
    .down_edge   (o_down_edge),
    .last_toggle (last_toggle)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; WAIT_RD has no timeout by design.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (i_start)     state_next = AFTER_IDLE;
      ST_LEAD:    if (guard_done)  state_next = ST_SHIFT;
      ST_SHIFT:   if (last_toggle) state_next = ST_WAIT_RD;
      ST_WAIT_RD: if (rd_full)     state_next = AFTER_WAIT;
      ST_TRAIL:   if (guard_done)  state_next = ST_DONE;
      ST_DONE:                     state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_busy    = 1'b1;
    o_cs_n    = 1'b0;
    o_done    = 1'b0;
    o_work_en = work_window(state_reg);
    unique case (state_reg)
      ST_IDLE: begin
        o_busy = 1'b0;
        o_cs_n = 1'b1;
      end
      ST_LEAD, ST_SHIFT, ST_WAIT_RD, ST_TRAIL: o_cs_n = 1'b0;
      ST_DONE: begin
        o_cs_n = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
        o_cs_n = 1'b1;
      end
    endcase
  end

  // Guard counter only advances inside LEAD/TRAIL, so it is idle when those phases are skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_cnt_reg <= '0;
    end else if (((state_reg == ST_LEAD) || (state_reg == ST_TRAIL)) && !guard_done) begin
      guard_cnt_reg <= guard_cnt_reg + 1'b1;
    end else begin
      guard_cnt_reg <= '0;
    end
  end

  // Shift datapath: pulses only act inside a frame, and reads saturate at DATA_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rd_cnt_reg   <= '0;
      wr_seen_reg  <= 1'b0;
    end else if ((state_reg == ST_IDLE) && i_start) begin
      tx_shift_reg <= i_tx_data;
      rx_shift_reg <= '0;
      rd_cnt_reg   <= '0;
      wr_seen_reg  <= 1'b0;
    end else if (in_frame) begin
      if (i_write_pulse) begin
        wr_seen_reg <= 1'b1;
        if (!SKIP_FIRST_WR || wr_seen_reg) begin
          tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
        end
      end
      if (i_read_pulse && !rd_full) begin
        rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], i_miso};
        rd_cnt_reg   <= rd_cnt_reg + 1'b1;
      end
    end
  end

  // Captured on entry to DONE so o_rx_data is already valid while o_done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg <= '0;
    end else if (state_next == ST_DONE) begin
      rx_data_reg <= rx_shift_reg;
    end
  end

  assign o_mosi    = tx_shift_reg[DATA_W-1];
  assign o_rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Self-checking bench for spi_xfer_seq: two channels (CPHA=0 and CPHA=1), each with a
// behavioural pulse generator and SPI slave; honours SPI_CS_GUARD_EN for the lead length.
module tb_spi_xfer_seq;

  localparam int CLK_DIV = 4;
  localparam int GUARD   = 2;
`ifdef SPI_CS_GUARD_EN
  localparam int LEAD = GUARD;
`else
  localparam int LEAD = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start       [2];
  logic [7:0] tx_data     [2];
  logic [7:0] rx_data     [2];
  logic [7:0] slave_word  [2];
  logic       loop        [2];
  logic       hold_last   [2];
  logic       man_rd      [2];
  int         rd_dly      [2];
  logic [1:0] busy, done, cs_n, sclk, mosi, miso, work_en, up_edge, down_edge;
  logic [1:0] write_pulse, read_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [7:0] rd_pipe;
    int         launch_cnt = 0;
    int         rd_emit = 0;
    int         kk;
    logic       samp_evt, launch_evt, pipe_out;

    // Pulse generator: CPOL=0, so the sample edge is rising for CPHA=0 and falling for CPHA=1.
    assign samp_evt   = work_en[gi] && ((gi == 1) ? down_edge[gi] : up_edge[gi]);
    assign launch_evt = work_en[gi] && ((gi == 1) ? up_edge[gi] : down_edge[gi]);
    assign pipe_out   = (rd_dly[gi] == 0) ? samp_evt : rd_pipe[3'(rd_dly[gi] - 1)];
    assign write_pulse[gi] = launch_evt;
    assign read_pulse[gi]  = (pipe_out && !(hold_last[gi] && rd_emit == 7)) || man_rd[gi];

    // Slave presents word MSB first, advancing on each launch edge (first one is a no-op for CPHA=1).
    always_comb begin
      kk = launch_cnt - gi;
      if (kk < 0) kk = 0;
      if (kk > 7) kk = 7;
    end
    assign miso[gi] = loop[gi] ? mosi[gi] : slave_word[gi][3'(7 - kk)];

    always @(posedge clk) begin
      if (!rst_n) rd_pipe <= '0;
      else        rd_pipe <= {rd_pipe[6:0], samp_evt};
      if (start[gi] && !busy[gi]) begin
        launch_cnt <= 0;
        rd_emit    <= 0;
      end else begin
        if (launch_evt) launch_cnt <= launch_cnt + 1;
        if (pipe_out)   rd_emit    <= rd_emit + 1;
      end
    end

    spi_xfer_seq #(
      .DATA_W    (8),
      .CLK_DIV   (CLK_DIV),
      .CPOL      (0),
      .CPHA      (gi),
      .GUARD_CYC (GUARD)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (start[gi]),
      .i_tx_data     (tx_data[gi]),
      .o_busy        (busy[gi]),
      .o_done        (done[gi]),
      .o_rx_data     (rx_data[gi]),
      .o_cs_n        (cs_n[gi]),
      .o_sclk        (sclk[gi]),
      .o_mosi        (mosi[gi]),
      .i_miso        (miso[gi]),
      .o_work_en     (work_en[gi]),
      .o_up_edge     (up_edge[gi]),
      .o_down_edge   (down_edge[gi]),
      .i_write_pulse (write_pulse[gi]),
      .i_read_pulse  (read_pulse[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] outs(input int g);
    return {cs_n[g], sclk[g], mosi[g], busy[g], done[g], work_en[g],
            up_edge[g], down_edge[g], rx_data[g]};
  endfunction

  // One frame: start, observe every cycle at negedge, then compare against the model.
  task automatic run_frame(input int g, input logic [7:0] tx, input bit lb,
                           input logic [7:0] sw, input int dly, input bit hold,
                           input int poke);
    int cs_cyc, edge_cyc, toggles, dones, bad_edge, man_cyc, done_cyc, wait_cyc;
    logic [7:0] mosi_obs, exp_rx;
    logic prev_sclk;
    bit finished;
    exp_rx = lb ? tx : sw;
    @(negedge clk);
    tx_data[g] = tx; loop[g] = lb; slave_word[g] = sw; rd_dly[g] = dly;
    hold_last[g] = hold; start[g] = 1'b1;
    cs_cyc = -1; edge_cyc = -1; toggles = 0; dones = 0; bad_edge = 0;
    man_cyc = -1; done_cyc = -1; wait_cyc = 0; mosi_obs = '0; finished = 0;
    prev_sclk = sclk[g];
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clk);
      start[g] = 1'b0; man_rd[g] = 1'b0;
      if (cyc == poke) begin start[g] = 1'b1; tx_data[g] = ~tx; end
      if (cs_n[g] == 1'b0 && cs_cyc < 0) cs_cyc = cyc;
      if (sclk[g] != prev_sclk) begin
        toggles++;
        if (edge_cyc < 0) edge_cyc = cyc;
      end
      if ((sclk[g] != prev_sclk) != (up_edge[g] || down_edge[g])) bad_edge++;
      prev_sclk = sclk[g];
      if (read_pulse[g]) mosi_obs = {mosi_obs[6:0], mosi[g]};
      if (hold && man_cyc < 0 && toggles == 16) begin
        wait_cyc++;
        if (wait_cyc == 3 * CLK_DIV) begin
          check($sformatf("ch%0d hold busy/work_en/done", g),
                {29'd0, busy[g], work_en[g], done[g]}, 32'b110);
          man_rd[g] = 1'b1;
          man_cyc = cyc;
        end
      end
      if (done[g]) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1;
    end
    check($sformatf("ch%0d frame finished", g), 32'(finished), 32'd1);
    check($sformatf("ch%0d sclk toggles", g), 32'(toggles), 32'd16);
    check($sformatf("ch%0d edge pulse align", g), 32'(bad_edge), 32'd0);
    check($sformatf("ch%0d done count", g), 32'(dones), 32'd1);
    check($sformatf("ch%0d cs to first edge", g), 32'(edge_cyc - cs_cyc), 32'(LEAD + CLK_DIV));
    if (!hold) check($sformatf("ch%0d mosi bits", g), 32'(mosi_obs), 32'(tx));
    else check($sformatf("ch%0d late read to done", g), 32'(done_cyc - man_cyc), 32'(2 + LEAD));
    check($sformatf("ch%0d rx_data", g), 32'(rx_data[g]), 32'(exp_rx));
    check($sformatf("ch%0d idle after frame", g), {30'd0, busy[g], cs_n[g]}, 32'b01);
    $display("frame ch%0d tx=%02h lb=%0d sw=%02h dly=%0d hold=%0d poke=%0d rx=%02h",
             g, tx, lb, sw, dly, hold, poke, rx_data[g]);
    hold_last[g] = 1'b0;
  endtask

  initial begin
    logic [7:0] r_tx, r_sw;
    int r_g;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 0; tx_data[g] = 0; slave_word[g] = 0; loop[g] = 0;
      hold_last[g] = 0; man_rd[g] = 0; rd_dly[g] = 0;
    end
    repeat (10) @(negedge clk);
    check("ch0 reset outputs", 32'(outs(0)), 32'h8000);
    check("ch1 reset outputs", 32'(outs(1)), 32'h8000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback with CPHA=0, then external slave data with CPHA=1.
    run_frame(0, 8'hA5, 1'b1, 8'h00, 1, 1'b0, -1);
    run_frame(1, 8'hC3, 1'b0, 8'h3C, 2, 1'b0, -1);
    // Start pulsed mid-frame must be dropped.
    run_frame(0, 8'h5A, 1'b1, 8'h00, 0, 1'b0, 10);
    run_frame(1, 8'h96, 1'b0, 8'h71, 3, 1'b0, 10);
    // Withheld final read keeps the frame open until it arrives.
    run_frame(0, 8'h81, 1'b0, 8'hB7, 2, 1'b1, -1);
    run_frame(1, 8'h18, 1'b0, 8'h4D, 1, 1'b1, -1);

    for (int i = 0; i < 8; i++) begin
      r_g  = int'($urandom_range(1, 0));
      r_tx = 8'($urandom);
      r_sw = 8'($urandom);
      run_frame(r_g, r_tx, 1'($urandom_range(1, 0)), r_sw,
                int'($urandom_range(CLK_DIV - 1, 0)), 1'b0, -1);
    end

    // Reset in the middle of SHIFT on both channels.
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      tx_data[g] = 8'hE7; loop[g] = 1'b1; rd_dly[g] = 1; start[g] = 1'b1;
    end
    @(negedge clk);
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (12) @(negedge clk);
    check("busy before mid-frame reset", {30'd0, busy}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    check("ch0 mid-frame reset outputs", 32'(outs(0)), 32'h8000);
    check("ch1 mid-frame reset outputs", 32'(outs(1)), 32'h8000);
    $display("reset asserted mid-SHIFT, outputs ch0=%04h ch1=%04h", outs(0), outs(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_frame(0, 8'h3E, 1'b1, 8'h00, 2, 1'b0, -1);
    run_frame(1, 8'hD2, 1'b0, 8'h6B, 0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_xfer_seq.md
SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 Parameter DATA_W, default 8: bits per frame, minimum 2.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period, minimum 2.
REQ-003 Parameter CPOL, default 0: SCLK idle level.
REQ-004 Parameter CPHA, default 0: clock phase, same value as the companion pulse generator.
REQ-005 Parameter GUARD_CYC, default 2: CS-to-SCLK guard length in clk cycles, minimum 1.
REQ-006 Port list (name, direction, width, meaning), one port per line:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  transfer request.
- i_tx_data  in  DATA_W  frame to send, MSB first.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.
- o_rx_data  out  DATA_W  last received frame.
- o_cs_n  out  1  chip select.
- o_sclk  out  1  serial clock.
- o_mosi  out  1  serial data out.
- i_miso  in  1  serial data in.
- o_work_en  out  1  enable to pulse generator.
- o_up_edge  out  1  one-cycle pulse on SCLK rising.
- o_down_edge  out  1  one-cycle pulse on SCLK falling.
- i_write_pulse  in  1  launch strobe from pulse generator.
- i_read_pulse  in  1  sample strobe from pulse generator.

Function
REQ-007 FSM states: IDLE, LEAD, SHIFT, WAIT_RD, TRAIL, DONE.
REQ-008 IDLE with i_start=1 shall load the tx shift register from i_tx_data, clear the rx and bit counters, and go to LEAD.
REQ-009 i_start while o_busy=1 shall be ignored, with no queueing.
REQ-010 o_busy shall be high in every state except IDLE; o_cs_n shall be low in LEAD, SHIFT, WAIT_RD and TRAIL.
REQ-011 LEAD shall last GUARD_CYC cycles with SCLK at CPOL, then go to SHIFT.
REQ-012 In SHIFT, the divider shall restart at entry, and o_sclk shall toggle every CLK_DIV cycles, for exactly 2*DATA_W toggles.
REQ-013 o_up_edge and o_down_edge shall pulse in the same cycle that o_sclk changes level.
REQ-014 After the last toggle, the FSM shall go to WAIT_RD.
REQ-015 o_mosi shall equal tx_shift[DATA_W-1], and tx_shift shall shift left on i_write_pulse.
REQ-016 With CPHA=1, the first i_write_pulse of a frame shall not shift.
REQ-017 On i_read_pulse, rx_shift shall become {rx_shift[DATA_W-2:0], i_miso} and the read count shall increment.
REQ-018 WAIT_RD shall persist until the read count reaches DATA_W, with no timeout; read pulses arriving during SHIFT count normally.
REQ-019 o_work_en shall be high in LEAD, SHIFT and WAIT_RD only, so a delayed final read pulse is never cancelled.
REQ-020 TRAIL shall last GUARD_CYC cycles, then go to DONE.
REQ-021 DONE shall last one cycle: o_done=1, o_rx_data<=rx_shift, then go to IDLE.
REQ-022 o_rx_data shall hold until the next DONE.
REQ-023 Read pulses beyond DATA_W in a frame, and any pulse received in IDLE, shall be ignored.
REQ-024 Integration constraint: the pulse generator's read delay shall be less than CLK_DIV cycles.

Reset
REQ-025 rst_n low shall, at any time including mid-frame, force: state IDLE, o_cs_n=1, o_sclk=CPOL, o_mosi=0, o_busy=0, o_done=0, o_work_en=0, edge outputs 0, o_rx_data=0, all counters 0.

Configuration
REQ-026 Macro SPI_CS_GUARD_EN, when defined, shall enable LEAD and TRAIL exactly as specified above.
REQ-027 Without SPI_CS_GUARD_EN, LEAD and TRAIL shall be zero-length:
- IDLE goes to SHIFT on start.
- WAIT_RD goes to DONE directly.
- GUARD_CYC is unused.

Structure
REQ-028 Shared package spi_pkg shall hold the FSM state enumeration and the parameter default constants.
REQ-029 Sub-module spi_clk_gen shall contain the divider, the SCLK register and the edge pulses, enabled only in SHIFT.

Verification
REQ-030 DATA_W=8, CLK_DIV=4, CPHA=0, i_miso tied to o_mosi, start with 0xA5 -> 16 SCLK toggles, o_done once, o_rx_data=0xA5.
REQ-031 CPHA=1, i_miso driven with 0x3C MSB-first -> o_rx_data=0x3C, and the observed MOSI bit sequence is 0xC3 for tx=0xC3.
REQ-032 i_start pulsed in the 10th cycle of a busy frame -> ignored, exactly one o_done.
REQ-033 rst_n asserted mid-SHIFT -> all outputs take their reset values in the same cycle; a new start afterwards completes normally.
REQ-034 Last i_read_pulse withheld -> o_busy and o_work_en stay high in WAIT_RD; the late pulse produces o_done after TRAIL.
REQ-035 With SPI_CS_GUARD_EN, GUARD_CYC=2 -> first SCLK edge occurs 2+CLK_DIV cycles after o_cs_n falls; without the macro -> CLK_DIV cycles after.
